ap_bank: RTL

- Bank of address-pointer registers that consumes the 3-bit pointer select produced by the CPU's pointer-select register.
- Holds NUM_AP pointers and executes pointer ops from the decoder on the selected pointer: load, increment, decrement, signed offset add, and memory accesses with post-increment or pre-decrement.
- Drives the data-memory address/request handshake for pointer-indirect accesses.
- Sits between the instruction decoder/pointer-select logic and the data-memory port.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/ap_bank_if.sv | 30 +++
 rtl/ap_regfile.sv | 36 +++
 rtl/ap_bank.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the decoder, the pointer-select register and the
// address-pointer bank: widths, pointer-op encoding and bank FSM states.
package cpu_pkg;

    localparam int AP_AW   = 16;
    localparam int AP_SELW = 3;
    localparam int AP_NUM  = 1 << AP_SELW;

    localparam logic [2:0] AP_NOP    = 3'd0;
    localparam logic [2:0] AP_LOAD   = 3'd1;
    localparam logic [2:0] AP_INC    = 3'd2;
    localparam logic [2:0] AP_DEC    = 3'd3;
    localparam logic [2:0] AP_ADDOFS = 3'd4;
    localparam logic [2:0] AP_ACC_PI = 3'd5;
    localparam logic [2:0] AP_ACC_PD = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREDEC,
        ST_REQ,
        ST_POSTINC
    } ap_state_e;

endpackage

// File: rtl/ap_bank_if.sv
// Decoder-side op handshake plus data-memory request port of the pointer bank.
interface ap_bank_if
    import cpu_pkg::*;
#(
    parameter int AW   = AP_AW,
    parameter int SELW = AP_SELW
);
    logic [SELW-1:0] ap_sel;
    logic            op_valid;
    logic [2:0]      op_code;
    logic [AW-1:0]   op_wdata;
    logic [7:0]      op_ofs;
    logic            op_ready;
    logic [AW-1:0]   ap_rdata;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack;
    logic            busy;

    // The master is the decoder plus the memory returning mem_ack.
    modport master (
        output ap_sel, op_valid, op_code, op_wdata, op_ofs, mem_ack,
        input  op_ready, ap_rdata, mem_req, mem_addr, busy
    );

    modport slave (
        input  ap_sel, op_valid, op_code, op_wdata, op_ofs, mem_ack,
        output op_ready, ap_rdata, mem_req, mem_addr, busy
    );
endinterface

// File: rtl/ap_regfile.sv
// Pointer register array: one write port, two combinational read ports
// (live select for the bus, latched select for multi-cycle accesses).
module ap_regfile #(
    parameter int AW     = 16,
    parameter int NUM_AP = 8,
    parameter int SELW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [SELW-1:0] waddr,
    input  logic [AW-1:0]   wdata,
    input  logic [SELW-1:0] raddr_a,
    output logic [AW-1:0]   rdata_a,
    input  logic [SELW-1:0] raddr_b,
    output logic [AW-1:0]   rdata_b
);

    logic [AW-1:0] regs [NUM_AP];

    // NOTE: the array is reset because software relies on every pointer
    // reading 0 after reset; that rules out a RAM macro, which is fine for 8 entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AP; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/ap_bank.sv
// Address-pointer bank: executes pointer ops on the selected pointer and runs
// pointer-indirect memory accesses with post-increment / pre-decrement.
module ap_bank
    import cpu_pkg::*;
#(
    parameter int AW     = AP_AW,
    parameter int NUM_AP = AP_NUM,
    parameter int SELW   = AP_SELW
) (
    input  logic     clk,
    input  logic     rst,
    ap_bank_if.slave bus
);

    ap_state_e       state, state_nxt;
    logic [SELW-1:0] cur_sel;
    logic            is_pi;
    logic            mem_req, mem_req_nxt;
    logic [AW-1:0]   mem_addr, mem_addr_nxt;
    logic            accept;

    logic            we;
    logic [SELW-1:0] waddr;
    logic [AW-1:0]   wdata;
    logic [AW-1:0]   live_val;
    logic [AW-1:0]   cur_val;
    logic [AW-1:0]   ofs_ext;

    ap_regfile #(
        .AW     (AW),
        .NUM_AP (NUM_AP),
        .SELW   (SELW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (bus.ap_sel),
        .rdata_a (live_val),
        .raddr_b (cur_sel),
        .rdata_b (cur_val)
    );

    assign ofs_ext      = {{(AW-8){bus.op_ofs[7]}}, bus.op_ofs};
    assign accept       = bus.op_valid && (state == ST_IDLE);
    assign bus.op_ready = (state == ST_IDLE);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.ap_rdata = live_val;
    assign bus.mem_req  = mem_req;
    assign bus.mem_addr = mem_addr;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_nxt    = state;
        we           = 1'b0;
        waddr        = cur_sel;
        wdata        = cur_val;
        mem_req_nxt  = mem_req;
        mem_addr_nxt = mem_addr;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    waddr = bus.ap_sel;
                    case (bus.op_code)
                        AP_LOAD: begin
                            we    = 1'b1;
                            wdata = bus.op_wdata;
                        end
                        AP_INC: begin
                            we    = 1'b1;
                            wdata = live_val + AW'(1);
                        end
                        AP_DEC: begin
                            we    = 1'b1;
                            wdata = live_val - AW'(1);
                        end
                        AP_ADDOFS: begin
                            we    = 1'b1;
                            wdata = live_val + ofs_ext;
                        end
                        AP_ACC_PI: begin
                            mem_req_nxt  = 1'b1;
                            mem_addr_nxt = live_val;
                            state_nxt    = ST_REQ;
                        end
                        AP_ACC_PD: state_nxt = ST_PREDEC;
                        default: ;
                    endcase
                end
            end
            ST_PREDEC: begin
                we           = 1'b1;
                wdata        = cur_val - AW'(1);
                mem_req_nxt  = 1'b1;
                mem_addr_nxt = cur_val - AW'(1);
                state_nxt    = ST_REQ;
            end
            ST_REQ: begin
                // mem_req is always high in REQ, so a stray ack elsewhere never lands here.
                if (bus.mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = is_pi ? ST_POSTINC : ST_IDLE;
                end
            end
            ST_POSTINC: begin
                we        = 1'b1;
                wdata     = cur_val + AW'(1);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_sel  <= '0;
            is_pi    <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nxt;
            mem_req  <= mem_req_nxt;
            mem_addr <= mem_addr_nxt;
            if (accept) begin
                cur_sel <= bus.ap_sel;
                is_pi   <= (bus.op_code == AP_ACC_PI);
            end
        end
    end

endmodule
